fir_sample_feeder: RTL and testbench

- Upstream neighbour of the FIR filter. Buffers 3-bit signed input samples from a producer through a valid/ready write port, using a small synchronous FIFO.
- Generates the 600 kHz sample strobe by dividing the 12 MHz clock by 20.
- Presents one sample per strobe on the FIR input pins: oFirIn drives the filter's iFirIn, and oEnSample_600kHz drives its iEnSample_600kHz.
- Handles FIFO underflow deterministically: the sample becomes zero and a sticky flag is set.

---
 rtl/fir_sample_feeder_pkg.sv | 13 +
 rtl/fir_sample_feeder_if.sv | 27 ++
 rtl/fir_in_fifo.sv | 55 +++++
 rtl/fir_sample_feeder.sv | 65 ++++++
 tb/tb_fir_sample_feeder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_sample_feeder_pkg.sv
// Constants and types shared by the sample feeder and the downstream FIR filter.
package fir_sample_feeder_pkg;

    localparam int CLK_HZ    = 12_000_000;
    localparam int SAMPLE_HZ = 600_000;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;
    localparam int DW        = 3;
    localparam int DEPTH     = 8;
    localparam int LVL_W     = $clog2(DEPTH) + 1;

    typedef logic signed [DW-1:0] sample_t;

endpackage

// File: rtl/fir_sample_feeder_if.sv
// Producer write port, strobe control and FIR-facing outputs of the sample feeder.
interface fir_sample_feeder_if #(
    parameter int DW    = fir_sample_feeder_pkg::DW,
    parameter int DEPTH = fir_sample_feeder_pkg::DEPTH
);

    logic                      iEnable;
    logic                      iWrValid;
    logic signed [DW-1:0]      iWrData;
    logic                      oWrReady;
    logic                      iClrUnderflow;
    logic                      oEnSample_600kHz;
    logic signed [DW-1:0]      oFirIn;
    logic [$clog2(DEPTH):0]    oLevel;
    logic                      oUnderflow;

    modport master (
        output iEnable, iWrValid, iWrData, iClrUnderflow,
        input  oWrReady, oEnSample_600kHz, oFirIn, oLevel, oUnderflow
    );

    modport slave (
        input  iEnable, iWrValid, iWrData, iClrUnderflow,
        output oWrReady, oEnSample_600kHz, oFirIn, oLevel, oUnderflow
    );

endinterface

// File: rtl/fir_in_fifo.sv
// Synchronous FIFO for input samples; full/empty come from the occupancy count.
module fir_in_fifo #(
    parameter int DW    = fir_sample_feeder_pkg::DW,
    parameter int DEPTH = fir_sample_feeder_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            wr_data,
    input  logic                     pop,
    output logic [DW-1:0]            rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    // NOTE: control state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// Buffers producer samples and presents one per 600 kHz strobe to the FIR filter.
module fir_sample_feeder #(
    parameter int DIV   = fir_sample_feeder_pkg::DIV,
    parameter int DEPTH = fir_sample_feeder_pkg::DEPTH,
    parameter int DW    = fir_sample_feeder_pkg::DW
) (
    input  logic               iClk_12MHz,
    input  logic               iRsn,
    fir_sample_feeder_if.slave bus
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0]           count;
    logic                    pop_edge;
    logic                    strobe;
    logic signed [DW-1:0]    fir_in;
    logic                    underflow;
    logic [DW-1:0]           head;
    logic                    full;
    logic                    empty;
    logic [$clog2(DEPTH):0]  level;

    fir_in_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (iClk_12MHz),
        .rst_n   (iRsn),
        .push    (bus.iWrValid),
        .wr_data (bus.iWrData),
        .pop     (pop_edge),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Popping one cycle early lets strobe and sample appear together at count DIV-1.
    assign pop_edge = bus.iEnable && (count == CW'(DIV - 2));

    always_ff @(posedge iClk_12MHz or negedge iRsn) begin
        if (!iRsn) begin
            count     <= '0;
            strobe    <= 1'b0;
            fir_in    <= '0;
            underflow <= 1'b0;
        end else begin
            if (!bus.iEnable)                 count <= '0;
            else if (count == CW'(DIV - 1))   count <= '0;
            else                              count <= count + 1'b1;

            strobe <= pop_edge;
            if (pop_edge) fir_in <= empty ? '0 : $signed(head);

            // A new underflow on the same edge as a clear must win.
            if (pop_edge && empty)       underflow <= 1'b1;
            else if (bus.iClrUnderflow)  underflow <= 1'b0;
        end
    end

    assign bus.oWrReady         = !full;
    assign bus.oEnSample_600kHz = strobe;
    assign bus.oFirIn           = fir_in;
    assign bus.oLevel           = level;
    assign bus.oUnderflow       = underflow;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_fir_sample_feeder;
    import fir_sample_feeder_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_sample_feeder_if bus ();

    fir_sample_feeder dut (
        .iClk_12MHz (clk),
        .iRsn       (rst_n),
        .bus        (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of samples, plus the number of consecutive enabled edges.
    sample_t q[$];
    sample_t m_fir;
    bit      m_strobe;
    bit      m_uf;
    int      run;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit pop_due();
        return bus.iEnable && ((run % DIV) == DIV - 2);
    endfunction

    task automatic model_reset();
        q.delete();
        m_fir    = '0;
        m_strobe = 1'b0;
        m_uf     = 1'b0;
        run      = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_strobe"},    bus.oEnSample_600kHz, m_strobe);
        check({tag, "_fir_in"},    bus.oFirIn,           m_fir);
        check({tag, "_level"},     bus.oLevel,           q.size());
        check({tag, "_wr_ready"},  bus.oWrReady,         q.size() < DEPTH);
        check({tag, "_underflow"}, bus.oUnderflow,       m_uf);
    endtask

    // One clock edge: model evaluated on the inputs held across the edge, outputs checked at +1.
    task automatic step(input string tag = "cyc");
        bit      pop, push, clr, was_empty;
        sample_t d;
        pop       = pop_due();
        push      = bus.iWrValid && (q.size() < DEPTH);
        clr       = bus.iClrUnderflow;
        d         = bus.iWrData;
        was_empty = (q.size() == 0);
        @(posedge clk);
        if (pop) m_fir = was_empty ? sample_t'(0) : q.pop_front();
        if (pop && was_empty) m_uf = 1'b1;
        else if (clr)         m_uf = 1'b0;
        if (push) q.push_back(d);
        m_strobe = pop;
        run      = bus.iEnable ? run + 1 : 0;
        #1;
        check_outputs(tag);
    endtask

    task automatic run_to_pop(input string tag);
        int n = 0;
        while (!pop_due() && n < 3 * DIV) begin
            step(tag);
            n++;
        end
        check({tag, "_reach_pop"}, n < 3 * DIV, 1);
    endtask

    task automatic push_one(input sample_t v, input string tag);
        bus.iWrValid = 1'b1;
        bus.iWrData  = v;
        step(tag);
        bus.iWrValid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sample_t t2_exp [3];
        sample_t v;
        int      n_strobe;
        int      k;
        int      saved_level;

        bus.iEnable       = 1'b0;
        bus.iWrValid      = 1'b0;
        bus.iWrData       = '0;
        bus.iClrUnderflow = 1'b0;
        model_reset();

        // 1: build some state, then assert reset between edges.
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) push_one(sample_t'(2 + (i % 2)), "t1_fill");
        bus.iEnable = 1'b1;
        for (int i = 0; i < 25; i++) step("t1_run");
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_strobe",    bus.oEnSample_600kHz, 0);
        check("t1_rst_fir_in",    bus.oFirIn,           0);
        check("t1_rst_level",     bus.oLevel,           0);
        check("t1_rst_wr_ready",  bus.oWrReady,         1);
        check("t1_rst_underflow", bus.oUnderflow,       0);
        model_reset();
        @(posedge clk);

        // 2: three samples, strobes in cycles 20, 40, 60.
        #1 rst_n = 1'b1;
        bus.iEnable = 1'b1;
        t2_exp[0] = 3; t2_exp[1] = -3; t2_exp[2] = 0;
        n_strobe = 0;
        for (int e = 1; e <= 60; e++) begin
            bus.iWrValid = (e <= 3);
            bus.iWrData  = (e <= 3) ? t2_exp[e-1] : sample_t'(0);
            step("t2");
            if (e == 3) check("t2_level_full3", bus.oLevel, 3);
            if (bus.oEnSample_600kHz === 1'b1) begin
                check("t2_strobe_cycle", e + 1, 20 * (n_strobe + 1));
                if (n_strobe < 3) begin
                    check("t2_sample", bus.oFirIn, t2_exp[n_strobe]);
                    check("t2_level_step", bus.oLevel, 2 - n_strobe);
                end
                n_strobe++;
            end
        end
        bus.iWrValid = 1'b0;
        check("t2_strobe_count", n_strobe, 3);

        // 3: fill to DEPTH without strobes, then a dropped write of 1.
        bus.iEnable = 1'b0;
        step("t3_idle");
        for (int i = 0; i < DEPTH; i++) begin
            do v = sample_t'($urandom_range(0, 7)); while (v == 1);
            push_one(v, "t3_fill");
        end
        check("t3_level_full", bus.oLevel, DEPTH);
        check("t3_ready_full", bus.oWrReady, 0);
        push_one(sample_t'(1), "t3_drop");
        check("t3_level_after_drop", bus.oLevel, DEPTH);
        bus.iEnable = 1'b1;
        for (int i = 0; i < DEPTH * DIV + 2; i++) begin
            step("t3_drain");
            if (bus.oEnSample_600kHz === 1'b1)
                check("t3_no_dropped_one", bus.oFirIn == 1, 0);
        end
        check("t3_drained", bus.oLevel, 0);

        // 4: underflow, sticky through valid pops, clear, and set winning over clear.
        run_to_pop("t4");
        step("t4_uf");
        check("t4_uf_fir", bus.oFirIn, 0);
        check("t4_uf_flag", bus.oUnderflow, 1);
        push_one(sample_t'(-2), "t4_push");
        push_one(sample_t'(3), "t4_push");
        for (int i = 0; i < 2; i++) begin
            run_to_pop("t4_valid");
            step("t4_valid_pop");
            check("t4_flag_held", bus.oUnderflow, 1);
        end
        bus.iClrUnderflow = 1'b1;
        step("t4_clr");
        bus.iClrUnderflow = 1'b0;
        check("t4_cleared", bus.oUnderflow, 0);
        run_to_pop("t4_race");
        bus.iClrUnderflow = 1'b1;
        step("t4_race");
        bus.iClrUnderflow = 1'b0;
        check("t4_set_wins", bus.oUnderflow, 1);

        // 5: simultaneous push and pop at level 4, then at level 0.
        bus.iClrUnderflow = 1'b1;
        step("t5_clr");
        bus.iClrUnderflow = 1'b0;
        bus.iEnable = 1'b0;
        for (int i = 0; i < 4; i++) push_one(sample_t'($urandom_range(0, 7)), "t5_fill");
        bus.iEnable = 1'b1;
        run_to_pop("t5_a");
        push_one(sample_t'(-1), "t5_both4");
        check("t5_level_kept", bus.oLevel, 4);
        for (int i = 0; i < 4; i++) begin
            run_to_pop("t5_drain");
            step("t5_drain");
        end
        check("t5_empty", bus.oLevel, 0);
        run_to_pop("t5_b");
        push_one(sample_t'(2), "t5_both0");
        check("t5_uf", bus.oUnderflow, 1);
        check("t5_level_one", bus.oLevel, 1);
        check("t5_uf_fir", bus.oFirIn, 0);

        // 6: enable dropped mid-count; next strobe 20 cycles after the rise.
        bus.iEnable = 1'b0;
        for (int i = 0; i < 3; i++) push_one(sample_t'($urandom_range(0, 7)), "t6_fill");
        bus.iEnable = 1'b1;
        for (int i = 0; i < 8; i++) step("t6_pre");
        saved_level = q.size();
        bus.iEnable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step("t6_low");
            check("t6_no_strobe", bus.oEnSample_600kHz, 0);
        end
        check("t6_level_kept", bus.oLevel, saved_level);
        bus.iEnable = 1'b1;
        k = 0;
        do begin
            step("t6_rise");
            k++;
        end while (bus.oEnSample_600kHz !== 1'b1 && k < 3 * DIV);
        check("t6_strobe_cycle", k + 1, DIV);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) bus.iEnable = !bus.iEnable;
            bus.iWrValid      = $urandom_range(0, 2) == 0;
            bus.iWrData       = sample_t'($urandom_range(0, 7));
            bus.iClrUnderflow = $urandom_range(0, 39) == 0;
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
